// File: rtl/riscv_core_pkg.sv
// Shared core types used by the divider arbiter and other shared execute units.
//   div_op_e        : funct3 encodings of the M-extension divide group
//   div_arb_state_e : sequencing states of the shared-divider arbiter
//   CAUSE_DIV_TIMEOUT : exception cause reported when the divider never completes
package riscv_core_pkg;

  typedef enum logic [2:0] {
    DIV_OP_DIV  = 3'b100,
    DIV_OP_DIVU = 3'b101,
    DIV_OP_REM  = 3'b110,
    DIV_OP_REMU = 3'b111
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } div_arb_state_e;

  localparam logic [31:0] CAUSE_DIV_TIMEOUT = 32'h0000_0018;

endpackage

// File: rtl/rr_arbiter.sv
// NUM_REQ-wide round-robin arbiter.
//   req_i : request vector
//   en_i  : arbitration enabled; the pointer advances only on an enabled grant
//   gnt_o : one-hot grant (zero when disabled or no request)
//   idx_o : index of the winner
//   vld_o : a winner exists
// The winner is the first asserted request at or after the pointer, scanning
// upward with wrap; on an enabled grant the pointer moves just past the winner.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  logic [IDX_W-1:0] win;

  always_comb begin
    int k;
    k     = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr_q) + i) % NUM_REQ;
      if (!found && req_i[k]) begin
        found = 1'b1;
        win   = IDX_W'(k);
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    idx_o = win;
    vld_o = found && en_i;
    ptr_d = ptr_q;
    if (found && en_i) begin
      gnt_o[win] = 1'b1;
      ptr_d      = IDX_W'((int'(win) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one multi-cycle divider between NUM_REQ requesters.
//   req_*  : per-requester valid/ready request with funct3 and operands
//   flush_i: kill the outstanding op of requester i (ignored for non-owners)
//   rsp_*  : buffered result/exception, valid one-hot to the owner
//   div_*  : start/done interface to the shared divider
// One op is in flight at a time. The watchdog aborts an op whose done never
// arrives and returns a TIMEOUT_CAUSE exception instead.
module div_arbiter
  import riscv_core_pkg::*;
#(
  parameter int          NUM_REQ       = 2,
  parameter int          DATA_WIDTH    = 32,
  parameter int          TIMEOUT       = 64,
  parameter logic [31:0] TIMEOUT_CAUSE = CAUSE_DIV_TIMEOUT
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*3-1:0]          req_op_type_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_b_i,
  input  logic [NUM_REQ-1:0]            flush_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  output logic [DATA_WIDTH-1:0]         rsp_result_o,
  output logic                          rsp_exc_valid_o,
  output logic [31:0]                   rsp_exc_cause_o,
  output logic                          div_start_o,
  output logic [2:0]                    div_op_type_o,
  output logic [DATA_WIDTH-1:0]         div_operand_a_o,
  output logic [DATA_WIDTH-1:0]         div_operand_b_o,
  input  logic [DATA_WIDTH-1:0]         div_result_i,
  input  logic                          div_done_i,
  input  logic                          div_exc_valid_i,
  input  logic [31:0]                   div_exc_cause_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  div_arb_state_e       state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                 exc_q, exc_d;
  logic [31:0]          cause_q, cause_d;

  logic                 arb_en, gnt_vld;
  logic [NUM_REQ-1:0]   gnt;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 own_flush, own_rdy, wd_exp;

  // Grant is held off while reset is asserted so all outputs read zero.
  assign arb_en = (state_q == IDLE) && rst_ni;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (req_valid_i),
    .en_i   (arb_en),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .vld_o  (gnt_vld)
  );

  assign own_flush = flush_i[owner_q];
  assign own_rdy   = rsp_ready_i[owner_q];
  assign wd_exp    = (wd_q == WD_LAST);

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    wd_d            = wd_q;
    res_d           = res_q;
    exc_d           = exc_q;
    cause_d         = cause_q;
    req_ready_o     = '0;
    div_start_o     = 1'b0;
    div_op_type_o   = '0;
    div_operand_a_o = '0;
    div_operand_b_o = '0;

    // Watchdog runs while the divider owns an op and saturates at its limit.
    if ((state_q == BUSY || state_q == DRAIN) && !wd_exp) wd_d = wd_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          req_ready_o     = gnt;
          div_start_o     = 1'b1;
          div_op_type_o   = req_op_type_i[int'(gnt_idx)*3 +: 3];
          div_operand_a_o = req_operand_a_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
          div_operand_b_o = req_operand_b_i[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
          owner_d         = gnt_idx;
          wd_d            = '0;
          state_d         = BUSY;
        end
      end
      BUSY: begin
        // Flush beats a same-cycle done: the result is dropped either way.
        if (own_flush) begin
          state_d = div_done_i ? IDLE : DRAIN;
        end else if (div_done_i) begin
          res_d   = div_result_i;
          exc_d   = div_exc_valid_i;
          cause_d = div_exc_cause_i;
          state_d = RESP;
        end else if (wd_exp) begin
          res_d   = '0;
          exc_d   = 1'b1;
          cause_d = TIMEOUT_CAUSE;
          state_d = RESP;
        end
      end
      DRAIN: begin
        // Wait out the killed op so the divider is free before re-granting.
        if (div_done_i || wd_exp) state_d = IDLE;
      end
      RESP: begin
        if (own_rdy || own_flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == RESP) rsp_valid_o[owner_q] = 1'b1;
  end

  assign rsp_result_o    = res_q;
  assign rsp_exc_valid_o = exc_q;
  assign rsp_exc_cause_o = cause_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      wd_q    <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wd_q    <= wd_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural divider stub of fixed
// latency (can be made to hang). Inputs are driven and outputs sampled on
// the falling edge.
module tb_div_arbiter;
  import riscv_core_pkg::*;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [NR-1:0]   req_valid_i, req_ready_o, flush_i, rsp_valid_o, rsp_ready_i;
  logic [NR*3-1:0] req_op_type_i;
  logic [NR*DW-1:0] req_operand_a_i, req_operand_b_i;
  logic [DW-1:0]   rsp_result_o, div_operand_a_o, div_operand_b_o, div_result_i;
  logic            rsp_exc_valid_o, div_start_o, div_done_i, div_exc_valid_i;
  logic [31:0]     rsp_exc_cause_o, div_exc_cause_i;
  logic [2:0]      div_op_type_o;

  always #5 clk_i = ~clk_i;

  div_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_type_i(req_op_type_i), .req_operand_a_i(req_operand_a_i),
    .req_operand_b_i(req_operand_b_i), .flush_i(flush_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_exc_valid_o(rsp_exc_valid_o),
    .rsp_exc_cause_o(rsp_exc_cause_o), .div_start_o(div_start_o),
    .div_op_type_o(div_op_type_o), .div_operand_a_o(div_operand_a_o),
    .div_operand_b_o(div_operand_b_o), .div_result_i(div_result_i),
    .div_done_i(div_done_i), .div_exc_valid_i(div_exc_valid_i),
    .div_exc_cause_i(div_exc_cause_i)
  );

  // ---- divider stub: done exactly stub_lat cycles after the start cycle ----
  int          stub_lat = 4;
  int          stub_cnt = 0;
  logic        stub_hang = 1'b0, extra_done = 1'b0, stub_done;
  logic [2:0]  s_op = '0;
  logic [31:0] s_a = '0, s_b = '0;

  function automatic logic [31:0] ref_res(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic ovf;
    logic [31:0] r;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0;
    case (op)
      DIV_OP_DIV:  r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      DIV_OP_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      DIV_OP_REM:  r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      DIV_OP_REMU: r = (b == 0) ? a : a % b;
      default:     r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk_i) begin
    if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
    if (div_start_o) begin
      stub_cnt <= stub_lat;
      s_op <= div_op_type_o;
      s_a  <= div_operand_a_o;
      s_b  <= div_operand_b_o;
    end
  end

  assign stub_done       = (stub_cnt == 1) && !stub_hang;
  assign div_done_i      = stub_done | extra_done;
  // Outside its own done the stub drives junk so a stray capture is visible.
  assign div_result_i    = stub_done ? ref_res(s_op, s_a, s_b) : 32'h5A5A_5A5A;
  assign div_exc_valid_i = stub_done && ((s_b == 0) || (s_a == 32'h8000_0000 && s_b == 32'hFFFF_FFFF));
  assign div_exc_cause_i = !stub_done ? 32'h0 : (s_b == 0) ? 32'h3 : 32'h7;

  // ---- checking ----
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic set_req(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op_type_i[r*3 +: 3]     = op;
    req_operand_a_i[r*DW +: DW] = a;
    req_operand_b_i[r*DW +: DW] = b;
  endtask

  // Advance until rsp_valid_o[r]; lat is the cycle offset from the grant.
  task automatic wait_rsp(input int r, input int lat0, output int lat);
    lat = lat0;
    while (!rsp_valid_o[r] && lat < 60) begin
      step();
      lat++;
    end
  endtask

  int  lat, n;
  logic saw_rsp;

  initial begin
    req_valid_i = '0; flush_i = '0; rsp_ready_i = '0;
    req_op_type_i = '0; req_operand_a_i = '0; req_operand_b_i = '0;

    // Both requesters valid from reset.
    set_req(0, DIV_OP_REM, 32'hFFFF_FFF9, 32'd2);
    set_req(1, DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    req_valid_i = 2'b11;
    repeat (3) step();
    chk("rst_req_ready", 64'(req_ready_o), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'h0);
    chk("rst_result", 64'(rsp_result_o), 64'h0);
    chk("rst_exc", 64'(rsp_exc_valid_o), 64'h0);
    chk("rst_cause", 64'(rsp_exc_cause_o), 64'h0);
    chk("rst_start", 64'(div_start_o), 64'h0);
    chk("rst_op", 64'(div_op_type_o), 64'h0);
    chk("rst_a", 64'(div_operand_a_o), 64'h0);
    chk("rst_b", 64'(div_operand_b_o), 64'h0);

    rst_ni = 1'b1; #1;
    chk("g0_ready", 64'(req_ready_o), 64'h1);
    chk("g0_start", 64'(div_start_o), 64'h1);
    chk("g0_op", 64'(div_op_type_o), 64'h6);
    chk("g0_a", 64'(div_operand_a_o), 64'hFFFF_FFF9);
    step(); req_valid_i = 2'b10;
    chk("busy_ready", 64'(req_ready_o), 64'h0);
    wait_rsp(0, 1, lat);
    chk("rem_lat", 64'(lat), 64'd5);
    chk("rem_result", 64'(rsp_result_o), 64'hFFFF_FFFF);
    chk("rem_exc", 64'(rsp_exc_valid_o), 64'h0);

    // Back-pressure: response held, nothing else accepted or started.
    for (int i = 0; i < 10; i++) begin
      extra_done = (i == 3);
      chk("stall_valid", 64'(rsp_valid_o), 64'h1);
      chk("stall_result", 64'(rsp_result_o), 64'hFFFF_FFFF);
      chk("stall_ready", 64'(req_ready_o), 64'h0);
      chk("stall_start", 64'(div_start_o), 64'h0);
      step();
    end
    extra_done = 1'b0;
    rsp_ready_i = 2'b01; step(); rsp_ready_i = '0;
    chk("g1_rsp_clear", 64'(rsp_valid_o), 64'h0);
    chk("g1_ready", 64'(req_ready_o), 64'h2);
    chk("g1_start", 64'(div_start_o), 64'h1);
    chk("g1_op", 64'(div_op_type_o), 64'h4);
    chk("g1_a", 64'(div_operand_a_o), 64'h8000_0000);
    step(); req_valid_i = '0;
    wait_rsp(1, 1, lat);
    chk("ovf_lat", 64'(lat), 64'd5);
    chk("ovf_result", 64'(rsp_result_o), 64'h8000_0000);
    chk("ovf_exc", 64'(rsp_exc_valid_o), 64'h1);
    chk("ovf_cause", 64'(rsp_exc_cause_o), 64'h7);
    rsp_ready_i = 2'b10; step(); rsp_ready_i = '0;

    // Stray done while idle is ignored.
    extra_done = 1'b1; step(); extra_done = 1'b0;
    chk("idle_done_ign", 64'(rsp_valid_o), 64'h0);

    // Pointer wrapped to 0; DIVU 100/7, then req1 DIV 5/0.
    set_req(0, DIV_OP_DIVU, 32'd100, 32'd7);
    set_req(1, DIV_OP_DIV, 32'd5, 32'd0);
    req_valid_i = 2'b11; #1;
    chk("rr_wrap_ready", 64'(req_ready_o), 64'h1);
    chk("divu_start", 64'(div_start_o), 64'h1);
    chk("divu_op", 64'(div_op_type_o), 64'h5);
    chk("divu_b", 64'(div_operand_b_o), 64'd7);
    step(); req_valid_i = 2'b10;
    wait_rsp(0, 1, lat);
    chk("divu_lat", 64'(lat), 64'd5);
    chk("divu_result", 64'(rsp_result_o), 64'd14);
    chk("divu_exc", 64'(rsp_exc_valid_o), 64'h0);
    rsp_ready_i = 2'b01; step(); rsp_ready_i = '0;
    chk("dz_ready", 64'(req_ready_o), 64'h2);
    step(); req_valid_i = '0;
    wait_rsp(1, 1, lat);
    chk("dz_result", 64'(rsp_result_o), 64'hFFFF_FFFF);
    chk("dz_exc", 64'(rsp_exc_valid_o), 64'h1);
    chk("dz_cause", 64'(rsp_exc_cause_o), 64'h3);
    rsp_ready_i = 2'b10; step(); rsp_ready_i = '0;

    // Owner flush two cycles after grant; req1 waits for the drain.
    set_req(0, DIV_OP_DIVU, 32'd100, 32'd7);
    set_req(1, DIV_OP_DIVU, 32'd50, 32'd5);
    req_valid_i = 2'b11; #1;
    chk("fl_grant0", 64'(req_ready_o), 64'h1);
    step(); req_valid_i = 2'b10;
    step(); flush_i = 2'b01;
    step(); flush_i = '0;
    chk("drain_rsp3", 64'(rsp_valid_o), 64'h0);
    chk("drain_ready3", 64'(req_ready_o), 64'h0);
    step();
    chk("drain_rsp4", 64'(rsp_valid_o), 64'h0);
    chk("drain_ready4", 64'(req_ready_o), 64'h0);
    step();
    chk("fl_grant1", 64'(req_ready_o), 64'h2);
    chk("fl_grant1_a", 64'(div_operand_a_o), 64'd50);
    flush_i = 2'b10;                      // owner flush in the grant cycle
    step(); flush_i = 2'b01; req_valid_i = '0;   // non-owner flush
    step(); flush_i = '0;
    wait_rsp(1, 2, lat);
    chk("fl_ign_lat", 64'(lat), 64'd5);
    chk("fl_ign_result", 64'(rsp_result_o), 64'd10);
    rsp_ready_i = 2'b10; step(); rsp_ready_i = '0;

    // Divider hangs: watchdog abort.
    stub_hang = 1'b1;
    set_req(0, DIV_OP_DIV, 32'd1, 32'd1);
    req_valid_i = 2'b01; #1;
    chk("to_grant", 64'(req_ready_o), 64'h1);
    step(); req_valid_i = '0;
    wait_rsp(0, 1, lat);
    chk("to_lat", 64'(lat), 64'd9);
    chk("to_result", 64'(rsp_result_o), 64'h0);
    chk("to_exc", 64'(rsp_exc_valid_o), 64'h1);
    chk("to_cause", 64'(rsp_exc_cause_o), 64'h18);
    rsp_ready_i = 2'b01; step(); rsp_ready_i = '0;

    // Flushed op on a hung divider leaves DRAIN via the watchdog.
    set_req(1, DIV_OP_DIVU, 32'd7, 32'd1);
    req_valid_i = 2'b10; #1;
    chk("dw_grant", 64'(req_ready_o), 64'h2);
    step(); req_valid_i = '0;
    step(); flush_i = 2'b10;
    step(); flush_i = '0; req_valid_i = 2'b01;
    n = 3; saw_rsp = 1'b0;
    while (!req_ready_o[0] && n < 40) begin
      saw_rsp |= |rsp_valid_o;
      step();
      n++;
    end
    chk("dw_regrant_lat", 64'(n), 64'd9);
    chk("dw_no_rsp", 64'(saw_rsp), 64'h0);
    step(); req_valid_i = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one multi-cycle divider between NUM_REQ requesters, e.g. the execute-stage M-unit and a second issue port or hart.
- Accepts requests with a valid/ready handshake and issues one operation at a time to the divider via start/done.
- Captures the result and exception status into a response buffer, and returns them to the owning requester with valid/ready.
- Supports per-requester flush and a completion watchdog.

Parameters:
- NUM_REQ, 2, number of requesters (>=2).
- DATA_WIDTH, 32, operand/result width.
- TIMEOUT, 64, cycles to wait for div_done_i before aborting; must exceed divider latency.
- TIMEOUT_CAUSE, 32'h18, exception cause reported on watchdog abort.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester request accepted
- req_op_type_i  in  NUM_REQ*3  funct3 (100 DIV, 101 DIVU, 110 REM, 111 REMU)
- req_operand_a_i  in  NUM_REQ*DATA_WIDTH  dividends
- req_operand_b_i  in  NUM_REQ*DATA_WIDTH  divisors
- flush_i  in  NUM_REQ  kill outstanding op of requester i
- rsp_valid_o  out  NUM_REQ  response valid, one-hot to owner
- rsp_ready_i  in  NUM_REQ  response accepted
- rsp_result_o  out  DATA_WIDTH  buffered result (shared)
- rsp_exc_valid_o  out  1  buffered exception flag
- rsp_exc_cause_o  out  32  buffered exception cause
- div_start_o  out  1  divider start pulse
- div_op_type_o  out  3  granted op type
- div_operand_a_o  out  DATA_WIDTH  granted dividend
- div_operand_b_o  out  DATA_WIDTH  granted divisor
- div_result_i  in  DATA_WIDTH  divider result
- div_done_i  in  1  divider completion pulse
- div_exc_valid_i  in  1  divider exception flag
- div_exc_cause_i  in  32  divider exception cause
- All ports are single-clock, clk_i; reset rst_ni is asynchronous, active-low.

Behaviour:
- States and transitions:
  - IDLE: on grant, go to BUSY.
  - BUSY: on div_done_i, capture and go to RESP. On flush_i[owner], go to DRAIN. On watchdog expiry, go to RESP with the timeout exception.
  - DRAIN: on div_done_i or watchdog expiry, go to IDLE; the result is discarded.
  - RESP: on rsp_ready_i[owner] or flush_i[owner], go to IDLE.
- Reset: state IDLE, rr pointer 0, owner 0, watchdog 0. Outputs all 0: req_ready_o, rsp_valid_o, rsp_result_o, rsp_exc_valid_o, rsp_exc_cause_o, div_start_o, div_op_type_o, div_operand_a_o, div_operand_b_o. Reset mid-operation abandons the op silently.
- Grant (combinational, IDLE only): first asserted req_valid_i at or after rr pointer, scanning upward with wrap.
  - req_ready_o[g] = 1 for the winner only.
  - Same cycle: div_start_o = 1, div_op/operands = requester g's inputs; elsewhere div_start_o = 0 and operand outputs = 0.
  - On grant: owner <= g, rr pointer <= (g+1) mod NUM_REQ.
- No request is accepted outside IDLE, i.e. one operation is in flight.
- Latency: handshake in cycle T, div_done_i at T+L, rsp_valid_o[owner] from T+L+1. Response held stable until rsp_ready_i[owner].
- Capture on div_done_i in BUSY: result, exc_valid, exc_cause into response registers.
  - The divider's RISC-V default results (x/0 -> all-ones quotient and dividend remainder; overflow -> dividend quotient and 0 remainder) pass through unchanged.
- div_done_i in IDLE or RESP is ignored.
- Watchdog: cleared on grant, increments in BUSY/DRAIN, saturates. On reaching TIMEOUT-1 in BUSY: response = result 0, exc_valid 1, cause TIMEOUT_CAUSE.
- Flush of a non-owner has no effect. Flush of the owner in the grant cycle is ignored (flush is sampled from BUSY onward). Flush and div_done_i in the same BUSY cycle: flush wins, next state IDLE with nothing returned.
- Simultaneous rsp_ready_i and a new req_valid_i: the new request is granted no earlier than the next cycle, in IDLE.

Decomposition:
- riscv_core_pkg gains:
  - div_op_e (the four funct3 codes);
  - div_arb_state_e (IDLE, BUSY, DRAIN, RESP);
  - CAUSE_DIV_TIMEOUT constant, which is the default for TIMEOUT_CAUSE.
- One sub-module: rr_arbiter (NUM_REQ-wide round-robin with pointer update on grant enable), reusable by other shared units.

Test Plan:
- Requester 0 issues DIVU 100/7 with a latency-4 divider -> div_start_o pulses in the handshake cycle; rsp_valid_o = 01 five cycles later, result 14, exc_valid 0.
- Both requesters valid from reset: req0 REM 0xFFFFFFF9 % 2, req1 DIV 0x80000000 / 0xFFFFFFFF.
  - req0 served first, result 0xFFFFFFFF.
  - req1 served next, result 0x80000000 with exc_valid passed through.
  - rr pointer returns to 0.
- req1 DIV 5/0 -> result 0xFFFFFFFF, exc_valid 1, cause equal to div_exc_cause_i.
- rsp_ready_i held 0 for 10 cycles -> rsp_valid_o and result remain stable, req_ready_o stays 0 for both, and no second div_start_o occurs.
- flush_i[0] two cycles after grant -> DRAIN, no rsp_valid_o. A pending req1 is granted the cycle after div_done_i.
- Divider stub that never asserts done, TIMEOUT = 8 -> rsp_valid_o at handshake + 9 with result 0, exc_valid 1, cause TIMEOUT_CAUSE.
